// File: rtl/release_seq_pkg.sv
// release_seq_pkg: shared state type and masked reduction helper for the release sequencer
package release_seq_pkg;
  typedef enum logic [1:0] {IDLE, WORK, FINISHED, STALL} state_t;
  // Channels outside the mask read as satisfied; callers zero-extend up to 64 channels
  function automatic logic masked_and(input logic [63:0] v, input logic [63:0] m);
    return &(v | ~m);
  endfunction
endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: saturating idle counter that flags the cycle the stall limit is reached
module stall_watchdog #(
  parameter int STALL_W     = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [STALL_W-1:0] LIM_M1 = STALL_W'(STALL_LIMIT - 1);
  logic [STALL_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign expired = (STALL_LIMIT != 0) && inc && (r_cnt == LIM_M1);
endmodule

// File: rtl/release_sequencer.sv
// release_sequencer: lockstep tuple release across a masked subset of store-and-release channels
module release_sequencer
  import release_seq_pkg::*;
#(
  parameter int NUM_STORAGES = 8,
  parameter int CNT_W        = 32,
  parameter int STALL_W      = 16,
  parameter int STALL_LIMIT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear,
  input  logic [NUM_STORAGES-1:0] channel_en,
  input  logic [NUM_STORAGES-1:0] in_is_stored,
  input  logic [NUM_STORAGES-1:0] out_ready,
  input  logic [NUM_STORAGES-1:0] local_last_processed,
  output logic [NUM_STORAGES-1:0] release_data,
  output logic [CNT_W-1:0]        next,
  output logic                    wrapped,
  output logic                    last_processed,
  output logic                    busy,
  output logic                    stall_error
);
  state_t r_state, w_nstate;
  logic [NUM_STORAGES-1:0] r_mask;
  logic [CNT_W-1:0] r_next;
  logic r_wrapped;
  logic w_stored_ok, w_ready_ok, w_last_ok, w_any, w_work, w_go, w_rel, w_fin, w_stall, w_expired;
  assign w_stored_ok = masked_and(64'(in_is_stored), 64'(r_mask));
  assign w_ready_ok  = masked_and(64'(out_ready), 64'(r_mask));
  assign w_last_ok   = masked_and(64'(local_last_processed), 64'(r_mask));
  assign w_any       = |(in_is_stored & r_mask);
  assign w_work      = (r_state == WORK) && !clear;
  assign w_go        = (r_state == IDLE) && start && !clear;
  assign w_rel       = w_work && w_stored_ok && w_ready_ok;
  assign w_fin       = w_work && !w_rel && w_last_ok && !w_any;
  assign w_stall     = w_work && !w_rel && !w_fin;
  stall_watchdog #(.STALL_W(STALL_W), .STALL_LIMIT(STALL_LIMIT)) u_wd (
    .clk(clk), .reset(reset), .clr(clear || w_go || w_rel), .inc(w_stall), .expired(w_expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_nstate;
  always_comb
    w_nstate = clear ? IDLE : w_go ? (|channel_en ? WORK : FINISHED) :
               w_fin ? FINISHED : w_expired ? STALL : r_state;
  always_comb begin
    release_data   = w_rel ? r_mask : '0;
    busy           = r_state == WORK;
    last_processed = r_state == FINISHED;
    stall_error    = r_state == STALL;
    next           = r_next;
    wrapped        = r_wrapped;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mask    <= '0;
      r_next    <= '0;
      r_wrapped <= 1'b0;
    end else if (clear || w_go) begin
      r_mask    <= clear ? '0 : channel_en;
      r_next    <= '0;
      r_wrapped <= 1'b0;
    end else if (w_rel) begin
      r_next <= r_next + 1'b1;
      if (&r_next) r_wrapped <= 1'b1;
    end
endmodule

// File: tb/tb_release_sequencer.sv
// tb_release_sequencer: directed scoreboard bench for the release sequencer (wide and narrow instances)
module tb_release_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0;
  logic [7:0] channel_en = '0, in_is_stored = '0, out_ready = '0, local_last = '0;
  logic [7:0] a_rel, b_rel;
  logic [31:0] a_next;
  logic [3:0] b_next;
  logic a_wr, a_lp, a_busy, a_se, b_wr, b_lp, b_busy, b_se;
  logic [63:0] sbq[$];
  int tests = 0, fails = 0;
  logic [31:0] mnext;

  always #5 clk = ~clk;

  release_sequencer #(.NUM_STORAGES(8), .CNT_W(32), .STALL_W(16), .STALL_LIMIT(1024)) u_a (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .channel_en(channel_en),
    .in_is_stored(in_is_stored), .out_ready(out_ready), .local_last_processed(local_last),
    .release_data(a_rel), .next(a_next), .wrapped(a_wr), .last_processed(a_lp),
    .busy(a_busy), .stall_error(a_se)
  );
  release_sequencer #(.NUM_STORAGES(8), .CNT_W(4), .STALL_W(16), .STALL_LIMIT(4)) u_b (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .channel_en(channel_en),
    .in_is_stored(in_is_stored), .out_ready(out_ready), .local_last_processed(local_last),
    .release_data(b_rel), .next(b_next), .wrapped(b_wr), .last_processed(b_lp),
    .busy(b_busy), .stall_error(b_se)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic do_start(input logic [7:0] en);
    channel_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    in_is_stored = '0;
    out_ready = '0;
    local_last = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    sbq.push_back(0); chk("rst_next", a_next);
    sbq.push_back(0); chk("rst_rel", a_rel);
    sbq.push_back(0); chk("rst_flags", {a_wr, a_lp, a_busy, a_se});
    reset = 1'b0;
    tick();
    // full-width release run then end-of-stream
    do_start(8'hFF);
    sbq.push_back(1); chk("t1_busy", a_busy);
    in_is_stored = 8'hFF; out_ready = 8'hFF;
    mnext = 0;
    for (int i = 0; i < 5; i++) begin
      sbq.push_back(8'hFF);
      #1 chk("t1_rel", a_rel);
      mnext++;
      tick();
    end
    sbq.push_back(mnext); chk("t1_next", a_next);
    in_is_stored = '0; local_last = 8'hFF;
    sbq.push_back(0);
    #1 chk("t1_rel_off", a_rel);
    tick();
    sbq.push_back(2'b10); chk("t1_fin", {a_lp, a_busy});
    do_start(8'h0F);
    sbq.push_back(5); chk("t1_frozen", a_next);
    sbq.push_back(1); chk("t1_start_ign", a_lp);
    do_clear();
    sbq.push_back(0); chk("t1_clr_next", a_next);
    sbq.push_back(0); chk("t1_clr_lp", a_lp);
    // subset mask, ch4 not ready but disabled
    do_start(8'h0F);
    channel_en = 8'hFF;
    in_is_stored = 8'h0F; out_ready = 8'hEF;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(8'h0F);
      #1 chk("t2_rel", a_rel);
      tick();
    end
    sbq.push_back(3); chk("t2_next", a_next);
    do_clear();
    // backpressure on one channel holds everyone
    do_start(8'hFF);
    in_is_stored = 8'hFF; out_ready = 8'hFB;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(0);
      #1 chk("t3_hold", a_rel);
      tick();
    end
    out_ready = 8'hFF;
    sbq.push_back(8'hFF);
    #1 chk("t3_rel", a_rel);
    tick();
    sbq.push_back(1); chk("t3_next", a_next);
    sbq.push_back(1); chk("t3_b_stall", b_se);
    do_clear();
    // watchdog on the narrow instance
    do_start(8'hFF);
    repeat (3) tick();
    sbq.push_back(0); chk("t4_pre", b_se);
    tick();
    sbq.push_back(2'b10); chk("t4_stall", {b_se, b_busy});
    sbq.push_back(0); chk("t4_a_nostall", a_se);
    in_is_stored = 8'hFF; out_ready = 8'hFF;
    sbq.push_back(0);
    #1 chk("t4_no_rel", b_rel);
    tick();
    sbq.push_back(0); chk("t4_frozen", b_next);
    do_clear();
    sbq.push_back(0); chk("t4_clr", {b_se, b_busy, b_lp});
    // wrap on 4-bit counter
    do_start(8'hFF);
    in_is_stored = 8'hFF; out_ready = 8'hFF;
    repeat (17) tick();
    sbq.push_back(1); chk("t5_b_next", b_next);
    sbq.push_back(1); chk("t5_b_wrap", b_wr);
    sbq.push_back(17); chk("t5_a_next", a_next);
    sbq.push_back(0); chk("t5_a_wrap", a_wr);
    do_clear();
    do_start(8'h00);
    sbq.push_back(2'b10); chk("t5_empty_fin", {b_lp, b_busy});
    do_clear();
    // same-cycle events
    channel_en = 8'hFF; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    sbq.push_back(0); chk("t6_sc_idle", {a_busy, a_lp});
    do_start(8'hFF);
    in_is_stored = 8'hFF; out_ready = 8'hFF; local_last = 8'hFF;
    sbq.push_back(8'hFF);
    #1 chk("t6_rel_wins", a_rel);
    tick();
    sbq.push_back(2'b01); chk("t6_still_work", {a_lp, a_busy});
    sbq.push_back(1); chk("t6_next", a_next);
    in_is_stored = '0;
    tick();
    sbq.push_back(2'b10); chk("t6_fin", {a_lp, a_busy});
    do_clear();
    do_start(8'hFF);
    in_is_stored = 8'hFF; out_ready = 8'hFF;
    tick();
    reset = 1'b1;
    #1;
    sbq.push_back(0); chk("t6_rst_rel", a_rel);
    sbq.push_back(0); chk("t6_rst_next", a_next);
    sbq.push_back(0); chk("t6_rst_flags", {a_wr, a_lp, a_busy, a_se});
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
